// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with a hardware clear engine,
// selectable read-during-write behaviour and an optional output register.
module ram_sp_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_s;
  logic                  busy_r;
  logic                  accept_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  q_valid_r;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Next-state logic: clear walks every address once, then returns to READY
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      READY: begin
        if (clr) begin
          state_s = CLEAR;
        end else begin
          state_s = READY;
        end
      end
      CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = READY;
          cnt_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          cnt_s   = cnt_r + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_s = READY;
        cnt_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // State, clear counter and busy flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      busy_r  <= (RESET_STATE == CLEAR);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == CLEAR);
    end
  end

  // Write-port arbitration: the clear engine owns the array while busy
  always_comb begin
    accept_s = en & ~busy_r;
    if (state_r == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = cnt_r;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      mem_we_s    = accept_s & we;
      mem_addr_s  = addr;
      mem_wdata_s = data;
    end
  end

  // Read data for the current access, honouring the read-during-write mode
  always_comb begin
    if ((RDW_MODE == 0) && we) begin
      rd_data_s = data;
    end else begin
      rd_data_s = mem[addr];
    end
  end

  // Storage array; deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] pipe_data_r;
      logic                  pipe_valid_r;

      // Two-stage result pipeline; q holds its value between results
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_data_r  <= {DATA_WIDTH{1'b0}};
          pipe_valid_r <= 1'b0;
          q_r          <= {DATA_WIDTH{1'b0}};
          q_valid_r    <= 1'b0;
        end else begin
          pipe_valid_r <= accept_s;
          if (accept_s) begin
            pipe_data_r <= rd_data_s;
          end
          q_valid_r <= pipe_valid_r;
          if (pipe_valid_r) begin
            q_r <= pipe_data_r;
          end
        end
      end
    end else begin : g_no_out_reg
      // Single-stage result register; q holds its value between results
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_r       <= {DATA_WIDTH{1'b0}};
          q_valid_r <= 1'b0;
        end else begin
          q_valid_r <= accept_s;
          if (accept_s) begin
            q_r <= rd_data_s;
          end
        end
      end
    end
  endgenerate

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign busy    = busy_r;

endmodule
